gbe_tx_status_collector: RTL

Runs in the user clock domain, directly upstream of the software-readable gbe status register. Monitors the 10GbE transmit interface and link, and assembles a registered 32-bit status word. Tracks:
- frames sent
- overflow events
- sticky error flags

Software clears counters and flags through a separate software-written control bit.

---
 rtl/gbe_status_pkg.sv | 36 +++
 rtl/gbe_status_edge_det.sv | 29 ++
 rtl/gbe_tx_status_collector.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gbe_status_pkg.sv
// Shared definitions for the gbe transmit status collector.
// Holds the status word layout, the frame-tracking FSM state type and the
// overflow counter saturation value.
package gbe_status_pkg;

  localparam int unsigned STATUS_W      = 32;
  localparam int unsigned FRAME_CNT_LSB = 0;
  localparam int unsigned FRAME_CNT_W   = 16;
  localparam int unsigned OVF_CNT_LSB   = 16;
  localparam int unsigned OVF_CNT_W     = 8;
  localparam int unsigned LINK_LOST_BIT = 27;
  localparam int unsigned OVERSIZE_BIT  = 28;
  localparam int unsigned AFULL_BIT     = 29;
  localparam int unsigned OVF_BIT       = 30;
  localparam int unsigned LINK_UP_BIT   = 31;

  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = OVF_CNT_W'(255);

  // Status word payload, MSB first.
  typedef struct packed {
    logic                   link_up;
    logic                   ovf_sticky;
    logic                   afull_sticky;
    logic                   oversize_sticky;
    logic                   link_lost_sticky;
    logic [2:0]             rsvd;
    logic [OVF_CNT_W-1:0]   ovf_count;
    logic [FRAME_CNT_W-1:0] frame_count;
  } status_t;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } tx_state_e;

endpackage

// File: rtl/gbe_status_edge_det.sv
// 1-bit edge detector: registers the input and flags rising/falling edges
// combinationally against that history, so an edge in cycle N can be acted
// on by registers that update at the end of cycle N.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset (history cleared to 0)
//   d_i     - monitored signal
//   q_o     - registered copy of d_i
//   rise_c  - d_i high now, low last cycle
//   fall_c  - d_i low now, high last cycle
module gbe_status_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_c,
  output logic fall_c
);

  // History register
  always_ff @(posedge clk_i) begin
    if (rst_i) q_o <= 1'b0;
    else       q_o <= d_i;
  end

  assign rise_c = d_i & ~q_o;
  assign fall_c = ~d_i & q_o;

endmodule

// File: rtl/gbe_tx_status_collector.sv
// Collects 10GbE transmit/link status into a registered 32-bit word for the
// software-readable status register: frame count, overflow count, sticky
// overflow/almost-full/oversize/link-lost flags and the current link state.
// Ports:
//   user_clk         - clock
//   user_rst         - synchronous active-high reset
//   tx_valid         - word accepted by the gbe core
//   tx_end_of_frame  - last word of frame (qualified by tx_valid)
//   tx_overflow      - tx buffer overflow level
//   tx_afull         - tx buffer almost-full level
//   link_up          - link status
//   sw_clr           - software clear level; acted on at its rising edge
//   status_word      - packed status (registered)
module gbe_tx_status_collector
  import gbe_status_pkg::*;
#(
  parameter int unsigned MAX_FRAME_WORDS = 1024,
  parameter int unsigned WCNT_W          = 11
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                tx_valid,
  input  logic                tx_end_of_frame,
  input  logic                tx_overflow,
  input  logic                tx_afull,
  input  logic                link_up,
  input  logic                sw_clr,
  output logic [STATUS_W-1:0] status_word
);

  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_FRAME_WORDS);

  tx_state_e         state_q;
  logic [WCNT_W-1:0] wcnt_q;
  status_t           status_q;
  status_t           status_d;

  logic clr_q, clr_rise, clr_fall;
  logic ovf_q, ovf_rise, ovf_fall;
  logic link_q, link_rise, link_fall;
  logic frame_done_c;
  logic oversize_c;
  logic unused_edges;

  gbe_status_edge_det u_clr_edge (
    .clk_i  (user_clk),
    .rst_i  (user_rst),
    .d_i    (sw_clr),
    .q_o    (clr_q),
    .rise_c (clr_rise),
    .fall_c (clr_fall)
  );

  gbe_status_edge_det u_ovf_edge (
    .clk_i  (user_clk),
    .rst_i  (user_rst),
    .d_i    (tx_overflow),
    .q_o    (ovf_q),
    .rise_c (ovf_rise),
    .fall_c (ovf_fall)
  );

  gbe_status_edge_det u_link_edge (
    .clk_i  (user_clk),
    .rst_i  (user_rst),
    .d_i    (link_up),
    .q_o    (link_q),
    .rise_c (link_rise),
    .fall_c (link_fall)
  );

  assign unused_edges = ^{clr_q, clr_fall, ovf_q, ovf_fall, link_q, link_rise};

  // Frame tracker; deliberately untouched by sw_clr so an in-flight frame
  // is still counted once it ends.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else if (tx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!tx_end_of_frame) begin
            state_q <= IN_FRAME;
            wcnt_q  <= WCNT_W'(1);
          end
        end
        IN_FRAME: begin
          if (tx_end_of_frame) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
          end else if (wcnt_q != WCNT_MAX) begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          wcnt_q  <= '0;
        end
      endcase
    end
  end

  // Any eof ends a frame, whether single-word (IDLE) or multi-word.
  assign frame_done_c = tx_valid & tx_end_of_frame;
  // Word arriving after MAX_FRAME_WORDS words are already in the frame.
  assign oversize_c   = tx_valid & (state_q == IN_FRAME) & (wcnt_q == WCNT_MAX);

  // Status next-state; a clear edge wins over every event in the same cycle.
  always_comb begin
    status_d         = status_q;
    status_d.link_up = link_up;
    status_d.rsvd    = '0;
    if (clr_rise) begin
      status_d.ovf_sticky       = 1'b0;
      status_d.afull_sticky     = 1'b0;
      status_d.oversize_sticky  = 1'b0;
      status_d.link_lost_sticky = 1'b0;
      status_d.ovf_count        = '0;
      status_d.frame_count      = '0;
    end else begin
      if (frame_done_c) begin
        status_d.frame_count = status_q.frame_count + FRAME_CNT_W'(1);
      end
      if (ovf_rise && (status_q.ovf_count != OVF_CNT_MAX)) begin
        status_d.ovf_count = status_q.ovf_count + OVF_CNT_W'(1);
      end
      if (tx_overflow) status_d.ovf_sticky       = 1'b1;
      if (tx_afull)    status_d.afull_sticky     = 1'b1;
      if (oversize_c)  status_d.oversize_sticky  = 1'b1;
      if (link_fall)   status_d.link_lost_sticky = 1'b1;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) status_q <= '0;
    else          status_q <= status_d;
  end

  assign status_word = status_q;

endmodule
